// File: rtl/port_test_pkg.sv
// Shared constants for the port test sweep block.
//   MisrPoly  : feedback polynomial applied when the MISR shifts out a 1
//   MisrSeed  : value loaded into the MISR on reset and at every sweep start
//   state_e   : sweep state machine encoding
package port_test_pkg;

    localparam logic [31:0] MisrPoly = 32'h04C1_1DB7;
    localparam logic [31:0] MisrSeed = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StSettle  = 2'b01,
        StCapture = 2'b10,
        StDone    = 2'b11
    } state_e;

endpackage

// File: rtl/port_test_misr.sv
// Multiple-input signature register with observation-bus folding.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, loads the seed
//   load  : load the seed (sweep start)
//   en    : compress one folded observation word into the signature
//   data  : observation bus, OBS_W bits
//   sig   : current signature register
module port_test_misr
    import port_test_pkg::*;
#(
    parameter int unsigned OBS_W = 236
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [OBS_W-1:0] data,
    output logic [31:0]      sig
);

    localparam int unsigned NChunk = (OBS_W + 31) / 32;

    logic [NChunk*32-1:0] padded;
    logic [31:0]          fold;
    logic [31:0]          sig_d;
    logic [31:0]          sig_q;

    always_comb begin
        // Zero-pad the top chunk so every chunk is a full 32-bit word.
        padded              = '0;
        padded[OBS_W-1:0]   = data;
        fold                = '0;
        for (int i = 0; i < NChunk; i++) begin
            fold = fold ^ padded[32*i +: 32];
        end

        sig_d = sig_q;
        if (load) begin
            sig_d = MisrSeed;
        end else if (en) begin
            sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MisrPoly : 32'h0) ^ fold;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= MisrSeed;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/port_test_sweep.sv
// Exhaustive operand sweep for a two-input device under test.
// Every (in2, in1) pair is driven in counting order, held SETTLE cycles, then the
// device outputs on obs are compressed into a 32-bit MISR signature.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   start      : begin a sweep (ignored while busy)
//   in1, in2   : operands, low and high halves of the vector counter
//   obs        : device outputs, sampled only in the capture cycle
//   busy       : sweep in progress
//   done       : sweep finished, held until the next start or reset
//   signature  : MISR register
//   vec_count  : vectors captured in the current or last sweep
module port_test_sweep
    import port_test_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned OBS_W  = 236,
    parameter int unsigned SETTLE = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   in1,
    output logic [WIDTH-1:0]   in2,
    input  logic [OBS_W-1:0]   obs,
    output logic               busy,
    output logic               done,
    output logic [31:0]        signature,
    output logic [2*WIDTH:0]   vec_count
);

    localparam int unsigned    CntW       = 2 * WIDTH;
    // Settle counter counts down to zero, so SETTLE cycles need a load of SETTLE-1.
    localparam logic [3:0]     SettleLoad = 4'(SETTLE - 1);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);
    localparam logic [CntW:0]   VecOne    = (CntW + 1)'(1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW:0]   vec_q, vec_d;
    logic [3:0]      settle_q, settle_d;
    logic            misr_load;
    logic            misr_en;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vec_d     = vec_q;
        settle_d  = settle_q;
        misr_load = 1'b0;
        misr_en   = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StSettle;
                    cnt_d     = '0;
                    vec_d     = '0;
                    settle_d  = SettleLoad;
                    misr_load = 1'b1;
                end
            end
            StSettle: begin
                if (settle_q == 4'd0) begin
                    state_d = StCapture;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            StCapture: begin
                misr_en = 1'b1;
                vec_d   = vec_q + VecOne;
                if (&cnt_q) begin
                    state_d = StDone;
                end else begin
                    cnt_d    = cnt_q + CntOne;
                    settle_d = SettleLoad;
                    state_d  = StSettle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            vec_q    <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
        end
    end

    port_test_misr #(
        .OBS_W (OBS_W)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (misr_load),
        .en   (misr_en),
        .data (obs),
        .sig  (signature)
    );

    assign in1       = cnt_q[WIDTH-1:0];
    assign in2       = cnt_q[CntW-1:WIDTH];
    assign busy      = (state_q == StSettle) || (state_q == StCapture);
    assign done      = (state_q == StDone);
    assign vec_count = vec_q;

endmodule
